// File: rtl/regfile_mp.sv
// Multi-port integer register file: one synchronous write port, NRD combinational read ports,
// optional hardwired-zero entry 0, optional write-to-read bypass and a hardware clear sweep.
module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                clr,
  output logic                init_done
);

  localparam logic [AW:0] NRegsW  = (AW+1)'(NREGS);
  localparam logic [AW:0] LastIdx = (AW+1)'(NREGS - 1);

  typedef enum logic {StInit, StReady} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     idx_q, idx_d;
  logic [XLEN-1:0] mem [NREGS];

  logic            wr_ok;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  assign init_done = (state_q == StReady);

  assign wr_ok = wr_en && (state_q == StReady) && ({1'b0, wr_addr} < NRegsW) &&
                 !(ZERO_REG && (wr_addr == '0));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    unique case (state_q)
      StInit: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q[AW-1:0];
        mem_wdata = '0;
        if (clr) begin
          idx_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LastIdx) state_d = StReady;
        end
      end
      StReady: begin
        // A write in the clr cycle still lands; the sweep then zeroes it anyway.
        mem_we = wr_ok;
        if (clr) begin
          state_d = StInit;
          idx_d   = '0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Array is deliberately not reset; the sweep provides the clean state.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rs_data = '0;
    for (int k = 0; k < NRD; k++) begin
      if (init_done && ({1'b0, rs_addr[k*AW +: AW]} < NRegsW) &&
          !(ZERO_REG && (rs_addr[k*AW +: AW] == '0))) begin
        if (BYPASS && wr_ok && (wr_addr == rs_addr[k*AW +: AW])) begin
          rs_data[k*XLEN +: XLEN] = wr_data;
        end else begin
          rs_data[k*XLEN +: XLEN] = mem[rs_addr[k*AW +: AW]];
        end
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the core's integer register file: one synchronous write port, NRD combinational read ports.
- Optional hardwired-zero entry 0 and optional same-cycle write-to-read bypass.
- Hardware clear sequencer zeroes every entry, one per cycle, after reset or on request.
- Sits in the decode stage; `init_done` gates pipeline issue.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of entries, 2..256; need not be a power of 2.
- NRD, 2, number of read ports, 1..4.
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rs_addr  in  NRD*AW  read addresses; port k = bits [k*AW +: AW].
- rs_data  out  NRD*XLEN  read data; port k = bits [k*XLEN +: XLEN]; combinational.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- clr  in  1  request a full clear sweep (single-cycle pulse or level).
- init_done  out  1  high when the array is valid and writes are accepted.

Behaviour:
- FSM has two states: INIT and READY. A counter `idx` (AW+1 bits) addresses the sweep.
- Reset (rst=1 at an edge):
  - state <= INIT, idx <= 0, init_done <= 0.
  - Array contents are not touched by reset itself.
  - rst has priority over everything, including mid-sweep; the sweep restarts at 0.
- INIT, each cycle:
  - mem[idx] <= 0 and idx <= idx+1.
  - When idx == NREGS-1, that entry is zeroed and state <= READY.
  - init_done rises exactly NREGS cycles after rst deasserts (32 with defaults).
  - clr seen in INIT sets idx <= 0; the sweep restarts.
- READY:
  - clr=1 at an edge: state <= INIT, idx <= 0, init_done <= 0 from the next cycle. A write presented in that same cycle is still performed.
  - Otherwise, wr_en=1 performs mem[wr_addr] <= wr_data.
- Writes are dropped when any of these hold:
  - state is INIT;
  - wr_addr >= NREGS;
  - ZERO_REG=1 and wr_addr == 0.
- Read port k (combinational, evaluated in priority order):
  1. init_done=0: output 0.
  2. rs_addr_k >= NREGS: output 0.
  3. ZERO_REG=1 and rs_addr_k == 0: output 0.
  4. BYPASS=1, wr_en=1, wr_addr == rs_addr_k, and the write is not dropped: output wr_data.
  5. Otherwise: output mem[rs_addr_k].
- BYPASS=0: a read of the address being written returns the old value; the new value is visible from the next cycle.
- All read ports are independent; identical addresses on several ports are legal.
- No multi-cycle latency: write-to-read latency is 1 cycle, or 0 with BYPASS.
- ZERO_REG=0: entry 0 is an ordinary register.

Test Plan:
- Reset hold, then release; write 0xFFFFFFFF to all addresses during INIT -> init_done rises exactly 32 cycles after release; all reads return 0; the INIT writes have no effect.
- READY: write x5=0xDEADBEEF; next cycle read rs0=5, rs1=5 -> both return 0xDEADBEEF.
- Same cycle: wr_en=1, wr_addr=7, wr_data=0x1234 with rs0=7 -> rs_data0=0x1234 in that cycle (BYPASS=1). Repeat with BYPASS=0 -> rs_data0 returns the prior value, then 0x1234 one cycle later.
- Write x0=0xAAAA5555 with rs0=0 in the same cycle and the next -> reads 0 both cycles. With ZERO_REG=0 -> reads 0xAAAA5555.
- Load x1..x31 with distinct values, pulse clr -> init_done low for 32 cycles then high; all entries read 0. Assert rst at sweep cycle 10 -> sweep restarts and init_done rises 32 cycles after rst release.
- NREGS=20, AW=5: write addr 25, read addr 25 -> reads 0; entries 0..19 are unaffected.
